// File: rtl/decoder_scan.sv
// Registered one-hot decoder driving register-file write enables, with an optional
// sequential sweep (clear/init) mode compiled in when DECODER_SCAN_EN is defined.
module decoder_scan #(
  parameter int SEL_W     = 3,
  parameter int SCAN_HOLD = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [2**SEL_W-1:0]   d,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  input  logic                  scan_start,
  output logic                  scan_busy,
  output logic                  scan_done,
  output logic [SEL_W-1:0]      scan_idx
);
  localparam int N_OUT = 2**SEL_W;

  logic [N_OUT-1:0] dec_d;
  logic [N_OUT-1:0] d_q;

  always_comb begin
    dec_d = '0;
    if (en) dec_d[sel] = 1'b1;
  end

  assign d = d_q;

`ifdef DECODER_SCAN_EN
  localparam int HW = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q;
  logic [HW-1:0]    hold_q;
  logic [SEL_W-1:0] idx_q;
  logic             busy_q, done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      d_q     <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          // A sweep request wins over a normal decode on the same edge.
          if (scan_start) begin
            state_q <= SCAN;
            d_q     <= {{(N_OUT-1){1'b0}}, 1'b1};
            idx_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b1;
          end else begin
            d_q <= dec_d;
          end
        end
        SCAN: begin
          if (hold_q == HW'(SCAN_HOLD-1)) begin
            hold_q <= '0;
            if (idx_q == '1) begin
              // Exit edge deliberately skips decoding en/sel.
              state_q <= IDLE;
              d_q     <= '0;
              idx_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
              d_q   <= d_q << 1;
            end
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign scan_busy = busy_q;
  assign scan_done = done_q;
  assign scan_idx  = idx_q;
`else
  logic unused_scan_start;
  assign unused_scan_start = scan_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) d_q <= '0;
    else       d_q <= dec_d;
  end

  assign scan_busy = 1'b0;
  assign scan_done = 1'b0;
  assign scan_idx  = '0;
`endif

endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised registered one-hot decoder with a built-in sequential sweep mode. It replaces fixed-width combinational decoders in the register-file write path, driving per-register write enables. In normal mode it decodes `sel` into a one-hot word. On request it walks every output in order, asserting each for a programmable number of cycles, which is used for register-file clear/initialisation after reset.

## Interface
- `SEL_W`, default 3: select width; legal 1..6. Derived `N_OUT = 2**SEL_W`.
- `SCAN_HOLD`, default 1: cycles each output stays asserted during a sweep; legal 1..16.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `d`  out  N_OUT  registered one-hot decode output.
- `sel`  in  SEL_W  select index (normal mode).
- `en`  in  1  decode enable (normal mode).
- `scan_start`  in  1  sweep request, level-sampled in IDLE.
- `scan_busy`  out  1  high while sweep in progress.
- `scan_done`  out  1  one-cycle pulse on sweep completion.
- `scan_idx`  out  SEL_W  index currently asserted by the sweep; 0 when idle.

## Operation
- States: IDLE and SCAN.
- IDLE:
  - Each edge: `d <= en ? (1 << sel) : 0`.
  - `scan_busy`=0, `scan_idx`=0.
  - `scan_done`=0, except on the cycle after leaving SCAN.
- IDLE -> SCAN when `scan_start`=1 at an edge:
  - Same edge: `d <= 1<<0`, `scan_idx <= 0`, hold counter <= 0, `scan_busy <= 1`.
  - `scan_start` has priority over `en`/`sel` when both are active.
- SCAN:
  - `en`, `sel` and `scan_start` are ignored.
  - Hold counter increments each edge.
  - When it reaches `SCAN_HOLD-1`: counter <= 0, `scan_idx` increments, `d` shifts to the next one-hot bit.
- SCAN -> IDLE after index `N_OUT-1` completes its hold:
  - `d <= 0`, `scan_busy <= 0`, `scan_done <= 1` for exactly one cycle, `scan_idx <= 0`.
  - The exit edge does not decode `en`/`sel`; normal decode resumes on the following edge.
- A `scan_start` sampled in the cycle `scan_done` is high is accepted; a back-to-back sweep begins.
- Invariant: `d` is one-hot or all-zero at all times.
- Index and hold counters wrap nowhere; terminal compares end the sweep.
- Reset mid-sweep: all outputs 0, state IDLE, counters 0, with no `scan_done` pulse.

## Timing
- Reset values: `d`=0, `scan_busy`=0, `scan_done`=0, `scan_idx`=0, state IDLE.
- Normal decode latency: 1 cycle, from `sel`/`en` at edge t to `d` valid after edge t.
- Sweep with `scan_start` sampled at edge t:
  - Bit k asserted during cycles t+k·H .. t+(k+1)·H−1, where H = `SCAN_HOLD`.
  - `scan_busy` high for exactly N_OUT·H cycles.
  - `scan_done` high in cycle t+N_OUT·H.
- No combinational path from any input to any output.

## Configuration
- `DECODER_SCAN_EN` defined: the sweep state machine, counters and the IDLE/SCAN behaviour above are compiled in.
- `DECODER_SCAN_EN` undefined:
  - Block is a pure registered decoder.
  - `scan_start` is ignored.
  - `scan_busy`, `scan_done` and `scan_idx` are tied to 0.
  - Ports remain present.

## Test plan
- Reset then normal decode, SEL_W=3: `en`=1, `sel`=0..7 one per cycle -> `d`=0x01,0x02,…,0x80, each one cycle later. `en`=0 -> `d`=0x00 next cycle.
- Sweep, SEL_W=3, SCAN_HOLD=1:
  - `scan_start` pulse with `en`=1, `sel`=5 -> `d`=0x01,0x02,…,0x80 over 8 cycles, then 0x00.
  - `scan_busy` high 8 cycles; `scan_done` high 1 cycle; `sel` never decoded during the sweep.
- Sweep, SCAN_HOLD=3 -> each `d` bit held 3 cycles; `scan_busy` high 24 cycles; `scan_idx` steps 0..7 every 3 cycles.
- Back-to-back sweep: `scan_start` held high continuously -> a new sweep starts the cycle `scan_done` is high. `scan_start` high during SCAN is ignored; there is no restart.
- Async reset asserted mid-sweep at `scan_idx`=4 -> `d`=0 and `scan_busy`=0 immediately, with no `scan_done` pulse. After release, normal decode resumes.
- Built without `DECODER_SCAN_EN`: `scan_start`=1 with `en`=1, `sel`=2 -> `d`=0x04. `scan_busy`, `scan_done` and `scan_idx` stay 0.
